// File: rtl/key_event_gen_if.sv
// Key event generator bus: time-base tick and key levels in, per-key event pulses out.
interface key_event_gen_if;
    logic       tick;
    logic [3:0] key_in;
    logic [3:0] press;
    logic [3:0] long_press;
    logic [3:0] key_repeat;
    logic [3:0] held;

    modport master (
        output tick,
        output key_in,
        input  press,
        input  long_press,
        input  key_repeat,
        input  held
    );

    modport slave (
        input  tick,
        input  key_in,
        output press,
        output long_press,
        output key_repeat,
        output held
    );
endinterface

// File: rtl/key_event_gen.sv
// Four independent key FSMs turning debounced levels into press / long-press events.
// Define KEY_EVENT_REPEAT_EN to add auto-repeat pulses while a long hold continues.
module key_event_gen #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic           clk,
    input  logic           rst,
    key_event_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } key_state_t;

    localparam logic [7:0] LONG_LIM = 8'(LONG_TICKS);

    if (LONG_TICKS < 2 || LONG_TICKS > 255 || REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_param_check
        $error("key_event_gen: LONG_TICKS must be 2..255 and REPEAT_TICKS 1..255");
    end

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [7:0] REPEAT_LIM = 8'(REPEAT_TICKS);
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    key_state_t state     [4];
    key_state_t state_nxt [4];
    logic [7:0] cnt       [4];
    logic [7:0] cnt_nxt   [4];
    logic [3:0] prev;
    logic [3:0] press_nxt, long_nxt, held_nxt;
    logic [3:0] press_q, long_q, held_q;
`ifdef KEY_EVENT_REPEAT_EN
    logic [3:0] rpt_nxt, rpt_q;
`endif

    always_comb begin
        press_nxt = '0;
        long_nxt  = '0;
        held_nxt  = '0;
`ifdef KEY_EVENT_REPEAT_EN
        rpt_nxt   = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            state_nxt[k] = state[k];
            cnt_nxt[k]   = cnt[k];
            case (state[k])
                IDLE: begin
                    // The edge cycle's tick is deliberately not counted.
                    if (bus.key_in[k] && !prev[k]) begin
                        state_nxt[k] = SHORT;
                        cnt_nxt[k]   = 8'd0;
                    end
                end
                SHORT: begin
                    if (!bus.key_in[k]) begin
                        state_nxt[k] = IDLE;
                        press_nxt[k] = 1'b1;
                    end else if (bus.tick) begin
                        if (sat_inc(cnt[k]) == LONG_LIM) begin
                            state_nxt[k] = LONG;
                            cnt_nxt[k]   = 8'd0;
                            long_nxt[k]  = 1'b1;
                        end else begin
                            cnt_nxt[k] = sat_inc(cnt[k]);
                        end
                    end
                end
                LONG: begin
                    if (!bus.key_in[k]) begin
                        state_nxt[k] = IDLE;
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    else if (bus.tick) begin
                        if (sat_inc(cnt[k]) == REPEAT_LIM) begin
                            cnt_nxt[k] = 8'd0;
                            rpt_nxt[k] = 1'b1;
                        end else begin
                            cnt_nxt[k] = sat_inc(cnt[k]);
                        end
                    end
`endif
                end
                default: state_nxt[k] = IDLE;
            endcase
            held_nxt[k] = (state_nxt[k] != IDLE);
        end
    end

    // Previous level resets high so keys held through reset stay silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= 8'd0;
            end
            prev    <= 4'hF;
            press_q <= '0;
            long_q  <= '0;
            held_q  <= '0;
`ifdef KEY_EVENT_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            for (int k = 0; k < 4; k++) begin
                state[k] <= state_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
            prev    <= bus.key_in;
            press_q <= press_nxt;
            long_q  <= long_nxt;
            held_q  <= held_nxt;
`ifdef KEY_EVENT_REPEAT_EN
            rpt_q   <= rpt_nxt;
`endif
        end
    end

    assign bus.press      = press_q;
    assign bus.long_press = long_q;
    assign bus.held       = held_q;
`ifdef KEY_EVENT_REPEAT_EN
    assign bus.key_repeat = rpt_q;
`else
    assign bus.key_repeat = '0;
`endif
endmodule

// File: tb/tb_key_event_gen.sv
// Directed and random stimulus for key_event_gen against a hold-duration reference model.
module tb_key_event_gen;
    localparam int LT = 100;
    localparam int RT = 20;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_event_gen_if bus();

    key_event_gen #(.LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: per key, whether a hold is in progress and how many ticks it has lasted.
    bit         m_active [4];
    int         m_n      [4];
    logic [3:0] m_prev;
    logic [3:0] e_press, e_long, e_rpt, e_held;
    int         o_press [4];
    int         o_long  [4];
    int         o_rpt   [4];

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_active[k] = 1'b0;
            m_n[k]      = 0;
        end
        m_prev  = 4'hF;
        e_press = '0;
        e_long  = '0;
        e_rpt   = '0;
        e_held  = '0;
    endtask

    task automatic model_step(input logic t, input logic [3:0] key);
        e_press = '0;
        e_long  = '0;
        e_rpt   = '0;
        for (int k = 0; k < 4; k++) begin
            if (m_active[k]) begin
                if (!key[k]) begin
                    if (m_n[k] < LT) e_press[k] = 1'b1;
                    m_active[k] = 1'b0;
                end else if (t) begin
                    m_n[k]++;
                    if (m_n[k] == LT) e_long[k] = 1'b1;
                    else if (REP_EN && m_n[k] > LT && ((m_n[k] - LT) % RT) == 0) e_rpt[k] = 1'b1;
                end
            end else if (key[k] && !m_prev[k]) begin
                m_active[k] = 1'b1;
                m_n[k]      = 0;
            end
            e_held[k] = m_active[k];
        end
        m_prev = key;
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 4; k++) begin
            o_press[k] = 0;
            o_long[k]  = 0;
            o_rpt[k]   = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".press"}, bus.press, e_press);
        chk({tag, ".long_press"}, bus.long_press, e_long);
        chk({tag, ".repeat"}, bus.key_repeat, e_rpt);
        chk({tag, ".held"}, bus.held, e_held);
        for (int k = 0; k < 4; k++) begin
            o_press[k] += int'(bus.press[k]);
            o_long[k]  += int'(bus.long_press[k]);
            o_rpt[k]   += int'(bus.key_repeat[k]);
        end
    endtask

    task automatic step(input string tag, input logic t, input logic [3:0] key);
        @(negedge clk);
        bus.tick   = t;
        bus.key_in = key;
        model_step(t, key);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input string tag, input int nticks, input logic [3:0] key);
        for (int i = 0; i < nticks; i++) begin
            step(tag, 1'b1, key);
            step(tag, 1'b0, key);
        end
    endtask

    task automatic expect_counts(input string tag, input int k, input int np, input int nl, input int nr);
        chk_int({tag, ".press_count"}, o_press[k], np);
        chk_int({tag, ".long_count"}, o_long[k], nl);
        chk_int({tag, ".repeat_count"}, o_rpt[k], nr);
    endtask

    initial begin
        logic [3:0] rkey;
        logic       rtick;

        rst        = 1'b1;
        bus.tick   = 1'b0;
        bus.key_in = 4'hF;
        model_reset();
        clear_obs();
        #2 rst = 1'b0;
        #1 check_all("reset_async");
        @(posedge clk);
        #1 check_all("reset_held");

        // All keys held while reset releases: nothing until re-pressed.
        @(negedge clk);
        rst = 1'b1;
        hold("hold_thru_reset", 50, 4'hF);
        step("hold_thru_reset_rel", 1'b0, 4'h0);
        step("hold_thru_reset_rel", 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) expect_counts("hold_thru_reset", k, 0, 0, 0);
        clear_obs();
        step("key3_edge", 1'b0, 4'b1000);
        hold("key3_hold", 10, 4'b1000);
        step("key3_rel", 1'b0, 4'b0000);
        step("key3_idle", 1'b0, 4'b0000);
        expect_counts("key3", 3, 1, 0, 0);
        for (int k = 0; k < 3; k++) expect_counts("key3_others", k, 0, 0, 0);

        // Short press of 30 ticks.
        clear_obs();
        step("short_edge", 1'b0, 4'b0001);
        hold("short_hold", 30, 4'b0001);
        step("short_rel", 1'b0, 4'b0000);
        step("short_idle", 1'b0, 4'b0000);
        expect_counts("short30", 0, 1, 0, 0);

        // 150-tick hold: long at 100, repeats at 120 and 140 when enabled.
        clear_obs();
        step("long_edge", 1'b0, 4'b0010);
        hold("long_hold", 150, 4'b0010);
        step("long_rel", 1'b0, 4'b0000);
        step("long_idle", 1'b0, 4'b0000);
        expect_counts("long150", 1, 0, 1, REP_EN ? 2 : 0);

        // Release on the same clk as the 100th tick.
        clear_obs();
        step("race_edge", 1'b0, 4'b0100);
        hold("race_hold", 99, 4'b0100);
        step("race_rel_tick", 1'b1, 4'b0000);
        step("race_idle", 1'b0, 4'b0000);
        expect_counts("race100", 2, 1, 0, 0);

        // Press, release, re-press on consecutive cycles; edge with tick.
        clear_obs();
        step("fast_p1", 1'b1, 4'b0001);
        step("fast_r1", 1'b1, 4'b0000);
        step("fast_p2", 1'b1, 4'b0001);
        step("fast_r2", 1'b0, 4'b0000);
        step("fast_idle", 1'b0, 4'b0000);
        expect_counts("fast", 0, 2, 0, 0);

        // All keys reach long press in the same cycle.
        clear_obs();
        step("multi_edge", 1'b1, 4'hF);
        hold("multi_hold", 100, 4'hF);
        step("multi_rel", 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) expect_counts("multi", k, 0, 1, 0);

        // Reset mid-hold aborts silently, outputs clear at once.
        clear_obs();
        step("abort_edge", 1'b0, 4'b0001);
        hold("abort_hold", 60, 4'b0001);
        chk("abort_pre.held", bus.held, 4'b0001);
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("abort_async");
        @(posedge clk);
        #1 check_all("abort_in_reset");
        @(negedge clk);
        rst = 1'b1;
        hold("abort_after", 5, 4'b0001);
        step("abort_rel", 1'b0, 4'b0000);
        step("abort_idle", 1'b0, 4'b0000);
        expect_counts("abort", 0, 0, 0, 0);

        // Random key activity with sparse toggles so long holds occur.
        rkey = 4'h0;
        for (int i = 0; i < 6000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 149) == 0) rkey[k] = ~rkey[k];
            end
            if ($urandom_range(0, 199) == 0) rkey = $urandom_range(0, 15);
            rtick = ($urandom_range(0, 1) == 1);
            step("random", rtick, rkey);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_event_gen.md
KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 The block SHALL have parameter LONG_TICKS, default 100, meaning the number of tick pulses a key must be held before a long press is reported; legal range 2..255.
REQ-002 The block SHALL have parameter REPEAT_TICKS, default 20, meaning the number of tick pulses between auto-repeat pulses; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low (0 = reset).
REQ-005 The block SHALL have port tick, input, 1 bit: a one-clk-wide 100 Hz enable pulse (10 ms time base).
REQ-006 The block SHALL have port key_in, input, 4 bits: debounced key levels, where 1 = pressed.
REQ-007 The block SHALL have port press, output, 4 bits: a one-clk pulse per key on release after a short hold.
REQ-008 The block SHALL have port long_press, output, 4 bits: a one-clk pulse per key when the hold reaches LONG_TICKS.
REQ-009 The block SHALL have port repeat, output, 4 bits: one-clk auto-repeat pulses per key while a long hold continues.
REQ-010 The block SHALL have port held, output, 4 bits: a level that is 1 while the key's FSM is not in IDLE.

Function
REQ-011 Each of the 4 keys SHALL have an independent FSM with states IDLE, SHORT and LONG, an 8-bit tick counter and a registered previous key level; keys SHALL NOT interact.
REQ-012 From IDLE, the FSM SHALL go to SHORT on a rising edge of key_in, defined as key_in=1 with previous level 0, and the counter SHALL clear to 0.
REQ-013 In SHORT, the counter SHALL increment on each tick while key_in=1.
REQ-014 In SHORT, when a tick would bring the counter to LONG_TICKS, the FSM SHALL assert long_press for that single cycle, go to LONG and clear the counter.
REQ-015 In SHORT, when key_in=0 is sampled, the FSM SHALL assert press for exactly one clk on the next cycle and return to IDLE.
REQ-016 In LONG, when key_in=0 is sampled, the FSM SHALL return to IDLE with no press pulse.
REQ-017 All outputs SHALL be registered, with a latency of 1 clk from the sampling edge that causes an event.
REQ-018 A rising edge and a tick in the same cycle: the edge SHALL take priority and that tick SHALL NOT be counted.
REQ-019 A release and a tick in the same cycle in SHORT: the release SHALL win, giving press and no long_press, even if that tick would have reached LONG_TICKS.
REQ-020 A press, release and re-press of a key within consecutive cycles SHALL each be recognised; no events SHALL be lost or merged.
REQ-021 The counter SHALL saturate and never wrap; tick pulses seen in IDLE SHALL be ignored.
REQ-022 Multiple keys SHALL be allowed to report events in the same cycle.

Reset
REQ-023 While rst=0, all FSMs SHALL be in IDLE, counters SHALL be 0, and press, long_press, repeat and held SHALL all be 0.
REQ-024 The registered previous key level SHALL reset to 1111, so a key held through reset produces no event until it is released and pressed again.
REQ-025 Asserting reset mid-hold SHALL abort the hold silently, with no pulse emitted.

Configuration
REQ-026 With macro KEY_EVENT_REPEAT_EN defined, in LONG the counter SHALL increment on each tick, and on reaching REPEAT_TICKS the FSM SHALL pulse repeat for one clk and clear the counter, repeating until release.
REQ-027 With KEY_EVENT_REPEAT_EN undefined, repeat SHALL be constant 0, the LONG counter SHALL be frozen, and no repeat logic SHALL be synthesised.

Verification
REQ-028 Scenario: key_in[0] high for 30 ticks, then low -> exactly one press[0] pulse 1 clk after the release is sampled, with long_press and repeat at 0.
REQ-029 Scenario: key_in[1] high for 150 ticks, REPEAT_EN defined -> long_press[1] at tick 100, repeat[1] at ticks 120 and 140, and no press[1] on release.
REQ-030 Scenario: same stimulus as REQ-029 with REPEAT_EN undefined -> long_press[1] at tick 100 and repeat stays 0 throughout.
REQ-031 Scenario: key_in[2] released on the same clk as its 100th tick -> press[2]=1 and long_press[2]=0.
REQ-032 Scenario: key_in=1111 while rst is deasserted, then 50 ticks, then release -> no events; a subsequent press of key 3 for 10 ticks gives press[3] only.
REQ-033 Scenario: rst pulsed low at tick 60 of a hold -> all outputs read 0 immediately (asynchronously) and no press or long_press pulse follows.
